// File: rtl/matrix_uart_print_pkg.sv
// Shared constants and encodings for the matrix UART printer.
//   ELEM_W / MAX_DIM : element width and largest legal row/column count
//   ASCII_*          : characters emitted on the UART
//   state_t          : printer FSM states
//   char_sel_t       : which character of the current token is being sent
package matrix_uart_print_pkg;

    localparam int ELEM_W  = 8;
    localparam int MAX_DIM = 5;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_WAIT_HI,
        ST_WAIT_LO,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        SEL_HUND,
        SEL_TENS,
        SEL_ONES,
        SEL_SPACE,
        SEL_CR,
        SEL_LF
    } char_sel_t;

endpackage

// File: rtl/byte_to_dec_digits.sv
// Combinational 8-bit unsigned to three decimal digits.
//   value : input byte
//   hund  : value / 100
//   tens  : (value / 10) % 10
//   ones  : value % 10
//   ndig  : number of significant digits (1..3); 0 counts as one digit
module byte_to_dec_digits (
    input  logic [7:0] value,
    output logic [3:0] hund,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic [1:0] ndig
);

    always_comb begin
        hund = 4'(value / 8'd100);
        tens = 4'((value / 8'd10) % 8'd10);
        ones = 4'(value % 8'd10);
        if (value >= 8'd100)
            ndig = 2'd3;
        else if (value >= 8'd10)
            ndig = 2'd2;
        else
            ndig = 2'd1;
    end

endmodule

// File: rtl/matrix_uart_print.sv
// Prints a latched matrix over a byte-wise UART transmitter as ASCII decimal,
// row-major, space separated within a row, CR LF after each row.
//   clk, rst_n    : clock, asynchronous active-low reset
//   start         : print request, only honoured in IDLE
//   mat_m, mat_n  : row / column count (legal range 1..MAX_DIM)
//   mat_data_flat : element k = r*n + c at bits [k*ELEM_W +: ELEM_W]
//   tx_busy       : UART busy flag
//   tx_data       : byte to send, valid with tx_start
//   tx_start      : one-cycle send request
//   busy          : print in progress
//   done          : one-cycle completion pulse
//   err           : pulses with done when the dimensions were illegal
module matrix_uart_print #(
    parameter int ELEM_W  = 8,
    parameter int MAX_DIM = 5,
    parameter int DATA_W  = 200
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [3:0]        mat_m,
    input  logic [3:0]        mat_n,
    input  logic [DATA_W-1:0] mat_data_flat,
    input  logic              tx_busy,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    output logic              busy,
    output logic              done,
    output logic              err
);

    import matrix_uart_print_pkg::*;

    localparam logic [3:0] MAX_DIM4 = 4'(MAX_DIM);

    state_t            state_q, state_d;
    char_sel_t         sel_q, sel_d;
    logic [3:0]        m_q, m_d, n_q, n_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [2:0]        r_q, r_d, c_q, c_d;
    logic [4:0]        idx_q, idx_d;
    logic [3:0]        hund_q, hund_d, tens_q, tens_d, ones_q, ones_d;
    logic              busy_d, done_d, err_d;

    logic [ELEM_W-1:0] elem;
    logic [3:0]        dig_h, dig_t, dig_o;
    logic [1:0]        ndig;
    logic              dims_bad, last_col, last_row;

    // Elements are read from the latched copy so input changes mid-print
    // cannot disturb the output.
    assign elem = data_q[32'(idx_q) * ELEM_W +: ELEM_W];

    byte_to_dec_digits u_digits (
        .value (elem),
        .hund  (dig_h),
        .tens  (dig_t),
        .ones  (dig_o),
        .ndig  (ndig)
    );

    assign dims_bad = (mat_m == 4'd0) || (mat_m > MAX_DIM4) ||
                      (mat_n == 4'd0) || (mat_n > MAX_DIM4);
    assign last_col = ({1'b0, c_q} == (n_q - 4'd1));
    assign last_row = ({1'b0, r_q} == (m_q - 4'd1));

    // tx_start is combinational so the first byte leaves the cycle after LOAD;
    // gating with tx_busy guarantees it never overlaps a busy UART.
    assign tx_start = (state_q == ST_SEND) && !tx_busy;

    always_comb begin
        tx_data = 8'h00;
        if (state_q == ST_SEND) begin
            case (sel_q)
                SEL_HUND:  tx_data = ASCII_ZERO | {4'h0, hund_q};
                SEL_TENS:  tx_data = ASCII_ZERO | {4'h0, tens_q};
                SEL_ONES:  tx_data = ASCII_ZERO | {4'h0, ones_q};
                SEL_SPACE: tx_data = ASCII_SPACE;
                SEL_CR:    tx_data = ASCII_CR;
                SEL_LF:    tx_data = ASCII_LF;
                default:   tx_data = 8'h00;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        m_d     = m_q;
        n_d     = n_q;
        data_d  = data_q;
        r_d     = r_q;
        c_d     = c_q;
        idx_d   = idx_q;
        hund_d  = hund_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        busy_d  = busy_q_int();
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    m_d    = mat_m;
                    n_d    = mat_n;
                    data_d = mat_data_flat;
                    r_d    = 3'd0;
                    c_d    = 3'd0;
                    idx_d  = 5'd0;
                    if (dims_bad) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                hund_d = dig_h;
                tens_d = dig_t;
                ones_d = dig_o;
                // Skip leading zeros: start at the most significant nonzero digit.
                case (ndig)
                    2'd3:    sel_d = SEL_HUND;
                    2'd2:    sel_d = SEL_TENS;
                    default: sel_d = SEL_ONES;
                endcase
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (!tx_busy)
                    state_d = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                if (tx_busy)
                    state_d = ST_WAIT_LO;
            end
            ST_WAIT_LO: begin
                if (!tx_busy) begin
                    state_d = ST_SEND;
                    case (sel_q)
                        SEL_HUND: sel_d = SEL_TENS;
                        SEL_TENS: sel_d = SEL_ONES;
                        SEL_ONES: sel_d = last_col ? SEL_CR : SEL_SPACE;
                        SEL_CR:   sel_d = SEL_LF;
                        SEL_SPACE: begin
                            c_d     = c_q + 3'd1;
                            idx_d   = idx_q + 5'd1;
                            state_d = ST_LOAD;
                        end
                        SEL_LF: begin
                            if (last_row) begin
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                                state_d = ST_DONE;
                            end else begin
                                c_d     = 3'd0;
                                r_d     = r_q + 3'd1;
                                idx_d   = idx_q + 5'd1;
                                state_d = ST_LOAD;
                            end
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    function automatic logic busy_q_int();
        return busy;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= SEL_HUND;
            m_q     <= '0;
            n_q     <= '0;
            data_q  <= '0;
            r_q     <= '0;
            c_q     <= '0;
            idx_q   <= '0;
            hund_q  <= '0;
            tens_q  <= '0;
            ones_q  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            m_q     <= m_d;
            n_q     <= n_d;
            data_q  <= data_d;
            r_q     <= r_d;
            c_q     <= c_d;
            idx_q   <= idx_d;
            hund_q  <= hund_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            busy    <= busy_d;
            done    <= done_d;
            err     <= err_d;
        end
    end

endmodule

// File: tb/tb_matrix_uart_print.sv
module tb_matrix_uart_print;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [3:0]   mat_m, mat_n;
    logic [199:0] mat_data_flat;
    logic         tx_busy = 1'b0;
    logic [7:0]   tx_data;
    logic         tx_start, busy, done, err;

    matrix_uart_print dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .mat_m         (mat_m),
        .mat_n         (mat_n),
        .mat_data_flat (mat_data_flat),
        .tx_busy       (tx_busy),
        .tx_data       (tx_data),
        .tx_start      (tx_start),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 clk = ~clk;

    // UART model: busy for busy_len cycles after each accepted tx_start.
    int busy_len = 1;
    int bcnt = 0;
    always @(posedge clk) begin
        if (bcnt != 0) begin
            tx_busy <= (bcnt != 1);
            bcnt    <= bcnt - 1;
        end else if (tx_start) begin
            tx_busy <= 1'b1;
            bcnt    <= busy_len;
        end
    end

    // Monitor, sampled mid-cycle.
    logic [7:0] bytes_q[$];
    int cyc = 0, done_cnt = 0, err_cnt = 0, busy_hi_cnt = 0, overlap_cnt = 0;
    int last_hi = 0, done_cyc = 0;
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (tx_start) bytes_q.push_back(tx_data);
        if (tx_start && tx_busy) overlap_cnt <= overlap_cnt + 1;
        if (tx_busy) last_hi <= cyc;
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (err) err_cnt <= err_cnt + 1;
        if (busy) busy_hi_cnt <= busy_hi_cnt + 1;
    end

    int n_checks = 0, n_pass = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_start(input logic [3:0] m, input logic [3:0] n);
        mat_m = m;
        mat_n = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, output int drops);
        int base, t;
        base  = done_cnt;
        t     = 0;
        drops = 0;
        while (done_cnt == base && t < budget) begin
            if (!busy && !done) drops++;
            tick();
            t++;
        end
        chk({tag, "_timeout"}, 32'(done_cnt != base), 32'd1);
    endtask

    task automatic chk_bytes(input string tag, input int base);
        chk({tag, "_len"}, 32'(bytes_q.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (base + i < bytes_q.size())
                chk($sformatf("%s[%0d]", tag, i), 32'(bytes_q[base + i]), 32'(exp_q[i]));
    endtask

    task automatic put(input int k, input logic [7:0] v);
        mat_data_flat[k*8 +: 8] = v;
    endtask

    initial begin
        int base, dbase, ebase, bbase, drops;
        rst_n = 1'b0;
        start = 1'b0;
        mat_m = '0;
        mat_n = '0;
        mat_data_flat = '0;
        repeat (3) tick();
        chk("reset_outs", 32'({tx_data, tx_start, busy, done, err}), 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();
        chk("idle_outs", 32'({tx_data, tx_start, busy, done, err}), 32'd0);

        // 2x2 {0,7,42,255}, immediate-ack UART, with first-byte latency
        busy_len = 1;
        mat_data_flat = '0;
        put(0, 8'd0); put(1, 8'd7); put(2, 8'd42); put(3, 8'd255);
        base = bytes_q.size(); dbase = done_cnt; ebase = err_cnt;
        do_start(4'd2, 4'd2);
        chk("lat_busy_k1", 32'(busy), 32'd1);
        chk("lat_txs_k1", 32'(tx_start), 32'd0);
        @(negedge clk);
        chk("lat_txs_k2", 32'(tx_start), 32'd1);
        chk("lat_data_k2", 32'(tx_data), 32'h30);
        #1;
        wait_done("m2x2", 500, drops);
        exp_q = '{8'h30, 8'h20, 8'h37, 8'h0D, 8'h0A, 8'h34, 8'h32, 8'h20,
                  8'h32, 8'h35, 8'h35, 8'h0D, 8'h0A};
        chk_bytes("m2x2", base);
        chk("m2x2_busy_at_done", 32'(busy), 32'd0);
        tick();
        chk("m2x2_done_cnt", 32'(done_cnt - dbase), 32'd1);
        chk("m2x2_err_cnt", 32'(err_cnt - ebase), 32'd0);

        // 1x1 value 100, slower UART; done two cycles after the last busy cycle
        busy_len = 3;
        repeat (3) tick();
        mat_data_flat = '0;
        put(0, 8'd100);
        base = bytes_q.size();
        do_start(4'd1, 4'd1);
        wait_done("m1x1", 500, drops);
        tick();
        exp_q = '{8'h31, 8'h30, 8'h30, 8'h0D, 8'h0A};
        chk_bytes("m1x1", base);
        chk("m1x1_busy_held", 32'(drops), 32'd0);
        chk("m1x1_done_after_lf", 32'(done_cyc - last_hi), 32'd2);

        // illegal dimensions: m=0,n=3 then m=6,n=1
        for (int t = 0; t < 2; t++) begin
            repeat (3) tick();
            base = bytes_q.size(); dbase = done_cnt; ebase = err_cnt; bbase = busy_hi_cnt;
            if (t == 0) do_start(4'd0, 4'd3);
            else        do_start(4'd6, 4'd1);
            chk($sformatf("bad%0d_done", t), 32'(done), 32'd1);
            chk($sformatf("bad%0d_err", t), 32'(err), 32'd1);
            chk($sformatf("bad%0d_busy", t), 32'(busy), 32'd0);
            repeat (6) tick();
            chk($sformatf("bad%0d_no_tx", t), 32'(bytes_q.size() - base), 32'd0);
            chk($sformatf("bad%0d_done_cnt", t), 32'(done_cnt - dbase), 32'd1);
            chk($sformatf("bad%0d_err_cnt", t), 32'(err_cnt - ebase), 32'd1);
            chk($sformatf("bad%0d_busy_never", t), 32'(busy_hi_cnt - bbase), 32'd0);
        end

        // 5x5 all 9, 20-cycle UART busy
        busy_len = 20;
        mat_data_flat = '0;
        for (int k = 0; k < 25; k++) put(k, 8'd9);
        base = bytes_q.size();
        do_start(4'd5, 4'd5);
        wait_done("m5x5", 3000, drops);
        tick();
        exp_q = {};
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                exp_q.push_back(8'h39);
                if (c < 4) exp_q.push_back(8'h20);
            end
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
        chk_bytes("m5x5", base);
        chk("m5x5_busy_held", 32'(drops), 32'd0);
        chk("m5x5_overlap", 32'(overlap_cnt), 32'd0);

        // second start and data change mid-print are ignored
        busy_len = 2;
        repeat (3) tick();
        mat_data_flat = '0;
        put(0, 8'd1); put(1, 8'd2); put(2, 8'd3); put(3, 8'd4);
        base = bytes_q.size(); dbase = done_cnt;
        do_start(4'd2, 4'd2);
        repeat (5) tick();
        for (int k = 0; k < 25; k++) put(k, 8'd99);
        do_start(4'd3, 4'd3);
        wait_done("midst", 500, drops);
        repeat (10) tick();
        exp_q = '{8'h31, 8'h20, 8'h32, 8'h0D, 8'h0A, 8'h33, 8'h20, 8'h34, 8'h0D, 8'h0A};
        chk_bytes("midst", base);
        chk("midst_done_cnt", 32'(done_cnt - dbase), 32'd1);

        // reset after three bytes of a 2x3 print, then a fresh print
        mat_data_flat = '0;
        for (int k = 0; k < 6; k++) put(k, 8'(k + 1));
        base = bytes_q.size();
        do_start(4'd2, 4'd3);
        for (int t = 0; t < 200 && bytes_q.size() - base < 3; t++) tick();
        chk("rst_reach3", 32'(bytes_q.size() - base), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("rst_outs", 32'({tx_data, tx_start, busy, done, err}), 32'd0);
        repeat (4) tick();
        chk("rst_no_more", 32'(bytes_q.size() - base), 32'd3);
        rst_n = 1'b1;
        repeat (5) tick();
        base = bytes_q.size();
        do_start(4'd2, 4'd3);
        wait_done("rst_again", 500, drops);
        tick();
        exp_q = '{8'h31, 8'h20, 8'h32, 8'h20, 8'h33, 8'h0D, 8'h0A,
                  8'h34, 8'h20, 8'h35, 8'h20, 8'h36, 8'h0D, 8'h0A};
        chk_bytes("rst_again", base);
        chk("overlap_total", 32'(overlap_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
